// File: rtl/riscv_32im_pkg.sv
// Shared RV32 load/store definitions: trap causes, funct3 encodings and the
// per-transaction metadata carried by the LSU pending FIFO.
package riscv_32im_pkg;

  typedef enum logic [1:0] {
    LSU_CAUSE_NONE       = 2'd0,
    LSU_CAUSE_MISALIGNED = 2'd1,
    LSU_CAUSE_ACCESS     = 2'd2,
    LSU_CAUSE_ILLEGAL    = 2'd3
  } lsu_cause_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Widest address the metadata can hold; narrower ADDR_W zero-extends into it.
  localparam int unsigned META_ADDR_W = 32;

  typedef struct packed {
    logic [2:0]             funct3;
    logic                   we;
    logic [1:0]             offset;
    logic [META_ADDR_W-1:0] addr;
    logic                   local_err;
    lsu_cause_e             cause;
  } lsu_meta_t;

endpackage

// File: rtl/lsu_meta_fifo.sv
// Generic synchronous FIFO with an occupancy counter; a push while full is
// dropped even when a pop happens in the same cycle.
module lsu_meta_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output T     head_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/lsu_ooo_pipe.sv
// Pipelined in-order LSU: issues to a valid/ready DMEM port with zero latency
// and keeps up to MAX_OUTSTANDING transactions' metadata for in-order responses.
module lsu_ooo_pipe
  import riscv_32im_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [1:0]        rsp_cause_o,
  output logic [ADDR_W-1:0] rsp_badaddr_o,
  output logic              dmem_req_valid_o,
  input  logic              dmem_req_ready_i,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  output logic [3:0]        dmem_be_o,
  output logic              dmem_we_o,
  input  logic              dmem_rsp_valid_i,
  output logic              dmem_rsp_ready_o,
  input  logic [31:0]       dmem_rdata_i,
  input  logic              dmem_rsp_err_i
);
  lsu_meta_t   push_meta, head;
  logic        full, empty, push, pop;
  logic        illegal, misaligned, local_err;
  logic [1:0]  offset;
  logic [31:0] load_shift, load_data;

  assign offset = req_addr_i[1:0];

  always_comb begin
    case (req_funct3_i)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      3'b100, 3'b101:         illegal = req_we_i;
      default:                illegal = 1'b0;
    endcase
    misaligned = ((req_funct3_i[1:0] == 2'b01) && offset[0]) ||
                 ((req_funct3_i[1:0] == 2'b10) && (offset != 2'b00));
  end

  assign local_err = illegal || misaligned;

  always_comb begin
    push_meta           = '0;
    push_meta.funct3    = req_funct3_i;
    push_meta.we        = req_we_i;
    push_meta.offset    = offset;
    push_meta.addr      = META_ADDR_W'(req_addr_i);
    push_meta.local_err = local_err;
    push_meta.cause     = illegal    ? LSU_CAUSE_ILLEGAL :
                          misaligned ? LSU_CAUSE_MISALIGNED : LSU_CAUSE_NONE;
  end

  // Local errors never touch DMEM, so they only need FIFO room to be accepted.
  assign req_ready_o      = !rst_i && !full && (local_err || dmem_req_ready_i);
  assign push             = req_valid_i && req_ready_o;
  assign dmem_req_valid_o = !rst_i && req_valid_i && !full && !local_err;
  assign dmem_addr_o      = {req_addr_i[ADDR_W-1:2], 2'b00};
  assign dmem_we_o        = req_we_i;
  assign dmem_wdata_o     = req_wdata_i << {offset, 3'b000};

  always_comb begin
    case (req_funct3_i[1:0])
      2'b00:   dmem_be_o = 4'b0001 << offset;
      2'b01:   dmem_be_o = 4'b0011 << offset;
      default: dmem_be_o = 4'b1111;
    endcase
    if (!req_we_i) begin
      dmem_be_o = 4'b0000;
    end
  end

  lsu_meta_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (lsu_meta_t)
  ) u_meta_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_meta),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .head_o      (head)
  );

  assign rsp_valid_o      = !empty && (head.local_err || dmem_rsp_valid_i);
  assign dmem_rsp_ready_o = !empty && !head.local_err && rsp_ready_i;
  assign pop              = rsp_valid_o && rsp_ready_i;
  assign rsp_badaddr_o    = ADDR_W'(head.addr);
  assign load_shift       = dmem_rdata_i >> {head.offset, 3'b000};

  always_comb begin
    case (head.funct3)
      F3_LB:   load_data = {{24{load_shift[7]}}, load_shift[7:0]};
      F3_LH:   load_data = {{16{load_shift[15]}}, load_shift[15:0]};
      F3_LBU:  load_data = {24'b0, load_shift[7:0]};
      F3_LHU:  load_data = {16'b0, load_shift[15:0]};
      default: load_data = load_shift;
    endcase
    rsp_err_o   = 1'b0;
    rsp_cause_o = LSU_CAUSE_NONE;
    rsp_rdata_o = '0;
    if (head.local_err) begin
      rsp_err_o   = 1'b1;
      rsp_cause_o = head.cause;
    end else if (dmem_rsp_err_i) begin
      rsp_err_o   = 1'b1;
      rsp_cause_o = LSU_CAUSE_ACCESS;
    end else if (!head.we) begin
      rsp_rdata_o = load_data;
    end
  end

endmodule

// File: tb/tb_lsu_ooo_pipe.sv
// Directed bench for lsu_ooo_pipe: inputs change on the falling edge and
// outputs are compared 1 time unit later, well clear of the rising edge.
module tb_lsu_ooo_pipe;
  import riscv_32im_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [2:0]  req_funct3_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o, rsp_badaddr_o;
  logic [1:0]  rsp_cause_o;
  logic        dmem_req_valid_o, dmem_req_ready_i, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        dmem_rsp_valid_i, dmem_rsp_ready_o, dmem_rsp_err_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  lsu_ooo_pipe #(.MAX_OUTSTANDING(4), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_cause_o(rsp_cause_o), .rsp_badaddr_o(rsp_badaddr_o),
    .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_we_o(dmem_we_o), .dmem_rsp_valid_i(dmem_rsp_valid_i),
    .dmem_rsp_ready_o(dmem_rsp_ready_o), .dmem_rdata_i(dmem_rdata_i),
    .dmem_rsp_err_i(dmem_rsp_err_i)
  );

  task automatic set_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
  endtask

  task automatic idle_inputs();
    req_valid_i      = 1'b0;
    req_we_i         = 1'b0;
    req_funct3_i     = F3_LW;
    req_addr_i       = '0;
    req_wdata_i      = '0;
    rsp_ready_i      = 1'b1;
    dmem_req_ready_i = 1'b1;
    dmem_rsp_valid_i = 1'b0;
    dmem_rsp_err_i   = 1'b0;
    dmem_rdata_i     = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle_inputs();
    set_req(1'b0, F3_LW, 32'h0000_0010, 32'h0);
    dmem_rsp_valid_i = 1'b1;
    @(negedge clk_i);
    #1;
    n_checks++;
    if ({req_ready_o, rsp_valid_o, dmem_req_valid_o, dmem_rsp_ready_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_handshake: got %b, expected 0000",
               {req_ready_o, rsp_valid_o, dmem_req_valid_o, dmem_rsp_ready_o});
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if ({req_ready_o, rsp_valid_o, dmem_req_valid_o, dmem_rsp_ready_o} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_release: got %b, expected 1000",
               {req_ready_o, rsp_valid_o, dmem_req_valid_o, dmem_rsp_ready_o});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] words [3];
    addrs = '{32'h100, 32'h104, 32'h108};
    words = '{32'hAABBCCDD, 32'h11223344, 32'h55667788};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk_i);
      idle_inputs();
      if (c < 3) set_req(1'b0, F3_LW, addrs[c], 32'h0);
      if (c >= 3 && c < 6) begin
        dmem_rsp_valid_i = 1'b1;
        dmem_rdata_i     = words[c-3];
      end
      #1;
      if (c < 3) begin
        n_checks++;
        if ({dmem_req_valid_o, req_ready_o, dmem_we_o, dmem_be_o, dmem_addr_o} !==
            {3'b110, 4'b0000, addrs[c]}) begin
          n_fail++;
          $display("FAIL b2b_issue%0d: got v=%b r=%b we=%b be=%b a=%h, expected a=%h",
                   c, dmem_req_valid_o, req_ready_o, dmem_we_o, dmem_be_o, dmem_addr_o, addrs[c]);
        end
      end
      if (c >= 3 && c < 6) begin
        n_checks++;
        if ({rsp_valid_o, dmem_rsp_ready_o, rsp_err_o, rsp_cause_o, rsp_rdata_o, rsp_badaddr_o} !==
            {3'b110, 2'd0, words[c-3], addrs[c-3]}) begin
          n_fail++;
          $display("FAIL b2b_rsp%0d: got v=%b e=%b c=%0d d=%h ba=%h, expected d=%h ba=%h",
                   c - 3, rsp_valid_o, rsp_err_o, rsp_cause_o, rsp_rdata_o, rsp_badaddr_o,
                   words[c-3], addrs[c-3]);
        end
      end else begin
        n_checks++;
        if (rsp_valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_norsp%0d: got rsp_valid=%b, expected 0", c, rsp_valid_o);
        end
      end
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s  [4];
    logic [31:0] adr  [4];
    logic [31:0] expd [4];
    f3s  = '{F3_LB, F3_LBU, F3_LH, F3_LHU};
    adr  = '{32'h203, 32'h203, 32'h202, 32'h202};
    expd = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      idle_inputs();
      set_req(1'b0, f3s[i], adr[i], 32'h0);
      #1;
      n_checks++;
      if ({dmem_req_valid_o, dmem_be_o, dmem_addr_o} !== {1'b1, 4'b0000, 32'h200}) begin
        n_fail++;
        $display("FAIL ext_issue%0d: got v=%b be=%b a=%h, expected a=00000200",
                 i, dmem_req_valid_o, dmem_be_o, dmem_addr_o);
      end
      @(negedge clk_i);
      idle_inputs();
      dmem_rsp_valid_i = 1'b1;
      dmem_rdata_i     = 32'h80FFFFFF;
      #1;
      n_checks++;
      if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b10, expd[i]}) begin
        n_fail++;
        $display("FAIL ext_rsp%0d: got v=%b e=%b d=%h, expected d=%h",
                 i, rsp_valid_o, rsp_err_o, rsp_rdata_o, expd[i]);
      end
    end
  endtask

  task automatic test_store_lanes();
    logic [2:0]  f3s [3];
    logic [31:0] adr [3];
    logic [31:0] wd  [3];
    logic [31:0] ewd [3];
    logic [31:0] ead [3];
    logic [3:0]  ebe [3];
    f3s = '{F3_SH, F3_SB, F3_SW};
    adr = '{32'h302, 32'h301, 32'h304};
    wd  = '{32'h0000BEEF, 32'h000000A5, 32'h12345678};
    ewd = '{32'hBEEF0000, 32'h0000A500, 32'h12345678};
    ead = '{32'h300, 32'h300, 32'h304};
    ebe = '{4'b1100, 4'b0010, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      idle_inputs();
      set_req(1'b1, f3s[i], adr[i], wd[i]);
      #1;
      n_checks++;
      if ({dmem_req_valid_o, dmem_we_o, dmem_be_o, dmem_wdata_o, dmem_addr_o} !==
          {2'b11, ebe[i], ewd[i], ead[i]}) begin
        n_fail++;
        $display("FAIL store%0d: got be=%b wd=%h a=%h, expected be=%b wd=%h a=%h",
                 i, dmem_be_o, dmem_wdata_o, dmem_addr_o, ebe[i], ewd[i], ead[i]);
      end
      @(negedge clk_i);
      idle_inputs();
      dmem_rsp_valid_i = 1'b1;
      dmem_rdata_i     = 32'hFFFFFFFF;
      #1;
      n_checks++;
      if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b10, 32'h0}) begin
        n_fail++;
        $display("FAIL store_rsp%0d: got v=%b e=%b d=%h, expected v=1 e=0 d=0",
                 i, rsp_valid_o, rsp_err_o, rsp_rdata_o);
      end
    end
  endtask

  task automatic test_misaligned_behind_load();
    @(negedge clk_i);
    idle_inputs();
    set_req(1'b0, F3_LW, 32'h400, 32'h0);
    @(negedge clk_i);
    idle_inputs();
    dmem_req_ready_i = 1'b0;
    set_req(1'b0, F3_LW, 32'h401, 32'h0);
    #1;
    n_checks++;
    if ({dmem_req_valid_o, req_ready_o, rsp_valid_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL mis_accept: got dv=%b rr=%b rv=%b, expected 010",
               dmem_req_valid_o, req_ready_o, rsp_valid_o);
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    n_checks++;
    if (rsp_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_wait: got rsp_valid=%b, expected 0", rsp_valid_o);
    end
    @(negedge clk_i);
    idle_inputs();
    dmem_rsp_valid_i = 1'b1;
    dmem_rdata_i     = 32'hCAFEF00D;
    #1;
    n_checks++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o, rsp_badaddr_o} !== {2'b10, 32'hCAFEF00D, 32'h400}) begin
      n_fail++;
      $display("FAIL mis_first: got v=%b e=%b d=%h ba=%h, expected d=cafef00d ba=00000400",
               rsp_valid_o, rsp_err_o, rsp_rdata_o, rsp_badaddr_o);
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    n_checks++;
    if ({rsp_valid_o, dmem_rsp_ready_o, rsp_err_o, rsp_cause_o, rsp_rdata_o, rsp_badaddr_o} !==
        {3'b101, 2'd1, 32'h0, 32'h401}) begin
      n_fail++;
      $display("FAIL mis_second: got v=%b dr=%b e=%b c=%0d d=%h ba=%h, expected c=1 ba=00000401",
               rsp_valid_o, dmem_rsp_ready_o, rsp_err_o, rsp_cause_o, rsp_rdata_o, rsp_badaddr_o);
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    n_checks++;
    if (rsp_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_drained: got rsp_valid=%b, expected 0", rsp_valid_o);
    end
  endtask

  task automatic test_local_errors();
    logic        wes [4];
    logic [2:0]  f3s [4];
    logic [31:0] adr [4];
    logic [1:0]  ecs [4];
    wes = '{1'b1, 1'b0, 1'b1, 1'b0};
    f3s = '{3'b100, 3'b110, 3'b101, F3_LH};
    adr = '{32'h600, 32'h601, 32'h603, 32'h605};
    ecs = '{2'd3, 2'd3, 2'd3, 2'd1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      idle_inputs();
      dmem_req_ready_i = 1'b0;
      set_req(wes[i], f3s[i], adr[i], 32'h0);
      #1;
      n_checks++;
      if ({dmem_req_valid_o, req_ready_o, rsp_valid_o} !== 3'b010) begin
        n_fail++;
        $display("FAIL lerr_accept%0d: got dv=%b rr=%b rv=%b, expected 010",
                 i, dmem_req_valid_o, req_ready_o, rsp_valid_o);
      end
      @(negedge clk_i);
      idle_inputs();
      #1;
      n_checks++;
      if ({rsp_valid_o, rsp_err_o, rsp_cause_o, rsp_rdata_o, rsp_badaddr_o} !==
          {2'b11, ecs[i], 32'h0, adr[i]}) begin
        n_fail++;
        $display("FAIL lerr_rsp%0d: got v=%b e=%b c=%0d d=%h ba=%h, expected c=%0d ba=%h",
                 i, rsp_valid_o, rsp_err_o, rsp_cause_o, rsp_rdata_o, rsp_badaddr_o, ecs[i], adr[i]);
      end
    end
  endtask

  task automatic test_full_fifo();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      idle_inputs();
      rsp_ready_i = 1'b0;
      set_req(1'b0, F3_LW, 32'h700 + 32'(4 * i), 32'h0);
      #1;
      n_checks++;
      if (req_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL full_fill%0d: got req_ready=%b, expected 1", i, req_ready_o);
      end
    end
    @(negedge clk_i);
    idle_inputs();
    rsp_ready_i = 1'b0;
    set_req(1'b0, F3_LW, 32'h710, 32'h0);
    #1;
    n_checks++;
    if ({req_ready_o, dmem_req_valid_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL full_block: got rr=%b dv=%b, expected 00", req_ready_o, dmem_req_valid_o);
    end
    @(negedge clk_i);
    dmem_rsp_valid_i = 1'b1;
    dmem_rdata_i     = 32'hF0;
    #1;
    n_checks++;
    if ({req_ready_o, rsp_valid_o, dmem_rsp_ready_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL full_stall: got rr=%b rv=%b dr=%b, expected 010",
               req_ready_o, rsp_valid_o, dmem_rsp_ready_o);
    end
    @(negedge clk_i);
    rsp_ready_i = 1'b1;
    #1;
    n_checks++;
    if ({req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_badaddr_o} !== {2'b01, 32'hF0, 32'h700}) begin
      n_fail++;
      $display("FAIL full_pop_refuse: got rr=%b rv=%b d=%h ba=%h, expected rr=0 d=f0 ba=00000700",
               req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_badaddr_o);
    end
    @(negedge clk_i);
    idle_inputs();
    rsp_ready_i = 1'b0;
    set_req(1'b0, F3_LW, 32'h710, 32'h0);
    #1;
    n_checks++;
    if (req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_reopen: got req_ready=%b, expected 1", req_ready_o);
    end
    for (int i = 1; i < 5; i++) begin
      @(negedge clk_i);
      idle_inputs();
      dmem_rsp_valid_i = 1'b1;
      dmem_rdata_i     = 32'hF0 + 32'(i);
      #1;
      n_checks++;
      if ({rsp_valid_o, rsp_rdata_o, rsp_badaddr_o} !==
          {1'b1, 32'hF0 + 32'(i), 32'h700 + 32'(4 * i)}) begin
        n_fail++;
        $display("FAIL full_drain%0d: got v=%b d=%h ba=%h, expected d=%h ba=%h",
                 i, rsp_valid_o, rsp_rdata_o, rsp_badaddr_o, 32'hF0 + 32'(i), 32'h700 + 32'(4 * i));
      end
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    n_checks++;
    if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL full_empty: got rv=%b rr=%b, expected 01", rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_fault_and_reset();
    @(negedge clk_i);
    idle_inputs();
    set_req(1'b0, F3_LW, 32'h500, 32'h0);
    @(negedge clk_i);
    idle_inputs();
    dmem_rsp_valid_i = 1'b1;
    dmem_rsp_err_i   = 1'b1;
    dmem_rdata_i     = 32'hDEADBEEF;
    #1;
    n_checks++;
    if ({rsp_valid_o, rsp_err_o, rsp_cause_o, rsp_rdata_o, rsp_badaddr_o} !==
        {2'b11, 2'd2, 32'h0, 32'h500}) begin
      n_fail++;
      $display("FAIL fault_rsp: got v=%b e=%b c=%0d d=%h ba=%h, expected c=2 d=0 ba=00000500",
               rsp_valid_o, rsp_err_o, rsp_cause_o, rsp_rdata_o, rsp_badaddr_o);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      idle_inputs();
      set_req(1'b0, F3_LW, 32'h510 + 32'(4 * i), 32'h0);
    end
    @(negedge clk_i);
    idle_inputs();
    rst_i = 1'b1;
    set_req(1'b0, F3_LW, 32'h518, 32'h0);
    dmem_rsp_valid_i = 1'b1;
    #1;
    n_checks++;
    if ({req_ready_o, rsp_valid_o, dmem_req_valid_o, dmem_rsp_ready_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b, expected 0000",
               {req_ready_o, rsp_valid_o, dmem_req_valid_o, dmem_rsp_ready_o});
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_inputs();
    dmem_rsp_valid_i = 1'b1;
    dmem_rdata_i     = 32'h2468ACE0;
    #1;
    n_checks++;
    if ({rsp_valid_o, dmem_rsp_ready_o, req_ready_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL midreset_empty: got rv=%b dr=%b rr=%b, expected 001",
               rsp_valid_o, dmem_rsp_ready_o, req_ready_o);
    end
    @(negedge clk_i);
    idle_inputs();
    set_req(1'b0, F3_LW, 32'h520, 32'h0);
    @(negedge clk_i);
    idle_inputs();
    dmem_rsp_valid_i = 1'b1;
    dmem_rdata_i     = 32'h13579BDF;
    #1;
    n_checks++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o, rsp_badaddr_o} !== {2'b10, 32'h13579BDF, 32'h520}) begin
      n_fail++;
      $display("FAIL postreset_load: got v=%b e=%b d=%h ba=%h, expected d=13579bdf ba=00000520",
               rsp_valid_o, rsp_err_o, rsp_rdata_o, rsp_badaddr_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_load_extend();
    test_store_lanes();
    test_misaligned_behind_load();
    test_local_errors();
    test_full_fifo();
    test_fault_and_reset();
    @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
